// File: rtl/spi_slave_core_pkg.sv
// Shared definitions for the SPI responder: version, register map, FSM encoding.
package spi_slave_core_pkg;

  localparam logic [7:0] VERSION = 8'd1;

  // Register window occupies the first 16 addresses; TX memory follows directly.
  localparam int unsigned REG_SPACE = 16;

  localparam logic [3:0] ADDR_VERSION = 4'd0;
  localparam logic [3:0] ADDR_STATUS  = 4'd1;
  localparam logic [3:0] ADDR_RXB_LO  = 4'd2;
  localparam logic [3:0] ADDR_RXB_HI  = 4'd3;
  localparam logic [3:0] ADDR_FRAMES  = 4'd4;
  localparam logic [3:0] ADDR_CTRL    = 4'd5;
  localparam logic [3:0] ADDR_MEMB_LO = 4'd14;
  localparam logic [3:0] ADDR_MEMB_HI = 4'd15;

  // Cycles after BUS_RST until the synchronizer pipeline holds real pin levels.
  localparam logic [2:0] WARM_CYCLES = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } state_t;

  // SPI pin bundle as seen by the synchronizer.
  typedef struct packed {
    logic sld;
    logic sdi;
    logic sen;
    logic sclk;
  } spi_pins_t;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_slave_in_sync.sv
// Two-flop synchronizer with a level/edge register stage; level, rise and fall are mutually aligned.
module spi_slave_in_sync #(
  parameter int unsigned W = 1
) (
  input  logic         BUS_CLK,
  input  logic         BUS_RST,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;

  // Synchronize pins, then register the level together with its edge pulses.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      meta  <= '0;
      sync  <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      meta  <= din;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI responder: oversampled SPI port shifting into RX memory and out of TX memory, basil bus access.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned MEM_BYTES = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 SCLK,
  input  logic                 SEN,
  input  logic                 SDI,
  input  logic                 SLD,
  output logic                 SDO
);

  localparam int unsigned MEM_BITS    = 8 * MEM_BYTES;
  localparam int unsigned IDX_W       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned TX_BASE     = REG_SPACE;
  localparam int unsigned RX_BASE     = TX_BASE + MEM_BYTES;
  localparam int unsigned MEM_END     = RX_BASE + MEM_BYTES;
  localparam logic [15:0] MEM_BYTES_W = 16'(MEM_BYTES);

  state_t     state_q, state_d;
  spi_pins_t  pin_in, pin_lvl, pin_rise, pin_fall;

  logic [7:0]  tx_mem [MEM_BYTES];
  logic [7:0]  rx_mem [MEM_BYTES];

  logic [15:0] bit_cnt_q;
  logic [15:0] rx_bits_q;
  logic [7:0]  frame_cnt_q;
  logic        busy_q, overflow_q, sld_seen_q, enable_q;
  logic [2:0]  warm_q;

  logic        start_c, capture_c, shift_c, close_c;
  logic        warm_done_c;
  logic        in_range_c;
  logic [IDX_W-1:0] bit_idx_c;
  logic [2:0]  bit_pos_c;
  logic        tx_bit_c;

  logic [31:0] add_u_c;
  logic [3:0]  reg_sel_c;
  logic        is_reg_c, is_tx_c, is_rx_c;
  logic [IDX_W-1:0] tx_off_c, rx_off_c;
  logic        soft_rst_c, clr_status_c, ctrl_wr_c, tx_wr_c;
  logic [7:0]  rd_mux_c;
  logic        unused_pins_c;

  assign pin_in = '{sld: SLD, sdi: SDI, sen: SEN, sclk: SCLK};

  spi_slave_in_sync #(
    .W ($bits(spi_pins_t))
  ) u_in_sync (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .din     (pin_in),
    .level   (pin_lvl),
    .rise    (pin_rise),
    .fall    (pin_fall)
  );

  assign unused_pins_c = ^{pin_lvl.sclk, pin_lvl.sld, pin_rise.sdi, pin_fall.sdi, pin_fall.sld};

  // Bus address decode into register window, TX memory and RX memory.
  assign add_u_c      = 32'(BUS_ADD);
  assign reg_sel_c    = add_u_c[3:0];
  assign is_reg_c     = add_u_c < REG_SPACE;
  assign is_tx_c      = (add_u_c >= TX_BASE) && (add_u_c < RX_BASE);
  assign is_rx_c      = (add_u_c >= RX_BASE) && (add_u_c < MEM_END);
  assign tx_off_c     = IDX_W'(add_u_c - TX_BASE);
  assign rx_off_c     = IDX_W'(add_u_c - RX_BASE);
  assign soft_rst_c   = BUS_WR && is_reg_c && (reg_sel_c == ADDR_VERSION);
  assign clr_status_c = BUS_WR && is_reg_c && (reg_sel_c == ADDR_STATUS);
  assign ctrl_wr_c    = BUS_WR && is_reg_c && (reg_sel_c == ADDR_CTRL);
  assign tx_wr_c      = BUS_WR && is_tx_c;

  // Frame bit n lives in byte n/8, MSB first; TX is read live so late bus writes still shift out.
  assign in_range_c  = 32'(bit_cnt_q) < MEM_BITS;
  assign bit_idx_c   = IDX_W'(bit_cnt_q >> 3);
  assign bit_pos_c   = 3'd7 - bit_cnt_q[2:0];
  assign tx_bit_c    = tx_mem[bit_idx_c][bit_pos_c];
  assign warm_done_c = (warm_q == WARM_CYCLES);

  // FSM state register.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle shift controls; SEN already high without a fresh rise means a frame we missed.
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    capture_c = 1'b0;
    shift_c   = 1'b0;
    close_c   = 1'b0;
    if (soft_rst_c) begin
      state_d = pin_lvl.sen ? ST_WAIT_IDLE : ST_IDLE;
    end else if (warm_done_c) begin
      case (state_q)
        ST_IDLE: begin
          if (pin_lvl.sen) begin
            if (pin_rise.sen && enable_q) begin
              state_d = ST_ACTIVE;
              start_c = 1'b1;
            end else begin
              state_d = ST_WAIT_IDLE;
            end
          end
        end
        ST_ACTIVE: begin
          capture_c = pin_rise.sclk;
          shift_c   = pin_fall.sclk;
          if (pin_fall.sen) begin
            close_c = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (!pin_lvl.sen) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shift counter, SDO, status and control registers.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      warm_q      <= '0;
      bit_cnt_q   <= '0;
      rx_bits_q   <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      sld_seen_q  <= 1'b0;
      enable_q    <= 1'b1;
      SDO         <= 1'b0;
    end else begin
      if (!warm_done_c) warm_q <= warm_q + 3'd1;
      if (soft_rst_c) begin
        bit_cnt_q   <= '0;
        rx_bits_q   <= '0;
        frame_cnt_q <= '0;
        busy_q      <= 1'b0;
        overflow_q  <= 1'b0;
        sld_seen_q  <= 1'b0;
        enable_q    <= 1'b1;
        SDO         <= 1'b0;
      end else begin
        if (start_c) begin
          bit_cnt_q <= '0;
          busy_q    <= 1'b1;
          SDO       <= tx_mem[0][7];
        end
        if (capture_c) bit_cnt_q <= sat_inc16(bit_cnt_q);
        if (shift_c)   SDO <= in_range_c ? tx_bit_c : 1'b0;
        // Frame close sees the count including a bit captured in the same cycle.
        if (close_c) begin
          rx_bits_q   <= capture_c ? sat_inc16(bit_cnt_q) : bit_cnt_q;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          busy_q      <= 1'b0;
          SDO         <= 1'b0;
        end
        overflow_q <= (overflow_q & ~clr_status_c) | (capture_c & ~in_range_c);
        sld_seen_q <= (sld_seen_q & ~clr_status_c) | pin_rise.sld;
        if (ctrl_wr_c) enable_q <= BUS_DATA_IN[0];
      end
    end
  end

  // TX memory written from the bus, RX memory bit-written from the shifter.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
    end else begin
      if (tx_wr_c) tx_mem[tx_off_c] <= BUS_DATA_IN;
      if (capture_c && in_range_c) rx_mem[bit_idx_c][bit_pos_c] <= pin_lvl.sdi;
    end
  end

  // Read data mux for the presented address.
  always_comb begin
    rd_mux_c = 8'h00;
    if (is_reg_c) begin
      case (reg_sel_c)
        ADDR_VERSION: rd_mux_c = VERSION;
        ADDR_STATUS:  rd_mux_c = {5'b0, sld_seen_q, overflow_q, busy_q};
        ADDR_RXB_LO:  rd_mux_c = rx_bits_q[7:0];
        ADDR_RXB_HI:  rd_mux_c = rx_bits_q[15:8];
        ADDR_FRAMES:  rd_mux_c = frame_cnt_q;
        ADDR_CTRL:    rd_mux_c = {7'b0, enable_q};
        ADDR_MEMB_LO: rd_mux_c = MEM_BYTES_W[7:0];
        ADDR_MEMB_HI: rd_mux_c = MEM_BYTES_W[15:8];
        default:      rd_mux_c = 8'h00;
      endcase
    end else if (is_tx_c) begin
      rd_mux_c = tx_mem[tx_off_c];
    end else if (is_rx_c) begin
      rd_mux_c = rx_mem[rx_off_c];
    end
  end

  // Registered read data, valid the cycle after the address.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST)     BUS_DATA_OUT <= 8'h00;
    else if (BUS_RD) BUS_DATA_OUT <= rd_mux_c;
  end

endmodule
